// File: rtl/est_ram_arbiter.sv
// Single-port access arbiter for the estimation-chain RAM.
// It shares one RAM port between three requesters: the MMSE writer, the
// channel-averaging engine (reads, writes, and locked pairs) and the equalizer
// read port. Read data comes back one cycle after the grant.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   mmse_req/addr/wdata, mmse_gnt     MMSE write port
//   avg_req/we/lock/addr/wdata        averaging request (lock reserves next cycle)
//   avg_gnt, avg_rvalid, avg_rdata    averaging grant and read return
//   eq_req/addr, eq_gnt               equalizer read request and grant
//   eq_rvalid, eq_rdata               equalizer read return
//   ram_en/we/addr/wdata, ram_rdata   RAM macro port (rdata valid 1 cycle after read)
module est_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mmse_req,
    input  logic [ADDR_WIDTH-1:0] mmse_addr,
    input  logic [DATA_WIDTH-1:0] mmse_wdata,
    output logic                  mmse_gnt,
    input  logic                  avg_req,
    input  logic                  avg_we,
    input  logic                  avg_lock,
    input  logic [ADDR_WIDTH-1:0] avg_addr,
    input  logic [DATA_WIDTH-1:0] avg_wdata,
    output logic                  avg_gnt,
    output logic                  avg_rvalid,
    output logic [DATA_WIDTH-1:0] avg_rdata,
    input  logic                  eq_req,
    input  logic [ADDR_WIDTH-1:0] eq_addr,
    output logic                  eq_gnt,
    output logic                  eq_rvalid,
    output logic [DATA_WIDTH-1:0] eq_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             rr_r;
    logic             lock_r;
    logic [CNT_W-1:0] avg_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic             avg_rvalid_r;
    logic             eq_rvalid_r;
    logic             avg_starved;
    logic             eq_starved;

    // A counter only reaches the limit while its requester keeps asking.
    assign avg_starved = avg_req && (avg_cnt == LIMIT);
    assign eq_starved  = eq_req  && (eq_cnt  == LIMIT);

    // Grant selection: lock, then starvation, then MMSE, then round-robin.
    always_comb begin
        mmse_gnt = 1'b0;
        avg_gnt  = 1'b0;
        eq_gnt   = 1'b0;
        if (rst) begin
            mmse_gnt = 1'b0;
        end else if (lock_r && avg_req) begin
            avg_gnt = 1'b1;
        end else if (avg_starved && eq_starved) begin
            avg_gnt = ~rr_r;
            eq_gnt  = rr_r;
        end else if (avg_starved) begin
            avg_gnt = 1'b1;
        end else if (eq_starved) begin
            eq_gnt = 1'b1;
        end else if (mmse_req) begin
            mmse_gnt = 1'b1;
        end else if (avg_req && eq_req) begin
            avg_gnt = ~rr_r;
            eq_gnt  = rr_r;
        end else if (avg_req) begin
            avg_gnt = 1'b1;
        end else if (eq_req) begin
            eq_gnt = 1'b1;
        end
    end

    // RAM port mux from the winner; address and data are zero when idle.
    always_comb begin
        ram_en    = mmse_gnt | avg_gnt | eq_gnt;
        ram_we    = mmse_gnt | (avg_gnt & avg_we);
        ram_addr  = '0;
        ram_wdata = '0;
        if (mmse_gnt) begin
            ram_addr  = mmse_addr;
            ram_wdata = mmse_wdata;
        end else if (avg_gnt) begin
            ram_addr  = avg_addr;
            ram_wdata = avg_wdata;
        end else if (eq_gnt) begin
            ram_addr  = eq_addr;
        end
    end

    // Arbitration state and read-return flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r         <= 1'b0;
            lock_r       <= 1'b0;
            avg_cnt      <= '0;
            eq_cnt       <= '0;
            avg_rvalid_r <= 1'b0;
            eq_rvalid_r  <= 1'b0;
        end else begin
            if (avg_gnt) begin
                rr_r <= 1'b1;
            end else if (eq_gnt) begin
                rr_r <= 1'b0;
            end
            lock_r       <= avg_gnt & avg_lock;
            avg_rvalid_r <= avg_gnt & ~avg_we;
            eq_rvalid_r  <= eq_gnt;
            if (avg_req && !avg_gnt) begin
                avg_cnt <= (avg_cnt == LIMIT) ? avg_cnt : avg_cnt + CNT_W'(1);
            end else begin
                avg_cnt <= '0;
            end
            if (eq_req && !eq_gnt) begin
                eq_cnt <= (eq_cnt == LIMIT) ? eq_cnt : eq_cnt + CNT_W'(1);
            end else begin
                eq_cnt <= '0;
            end
        end
    end

    // A read granted just before reset must not report valid data.
    assign avg_rvalid = avg_rvalid_r & ~rst;
    assign eq_rvalid  = eq_rvalid_r  & ~rst;
    assign avg_rdata  = ram_rdata;
    assign eq_rdata   = ram_rdata;

endmodule

// File: tb/tb_est_ram_arbiter.sv
// Testbench for est_ram_arbiter: directed scenarios with literal expectations,
// a short constrained soak, and a per-cycle reference model of the arbitration
// policy plus a reference memory for read data.
module tb_est_ram_arbiter;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned LIMIT = 4;
    localparam int NONE = 3, MMSE = 0, AVG = 1, EQ = 2;

    logic          clk;
    logic          rst;
    logic          mmse_req, avg_req, avg_we, avg_lock, eq_req;
    logic [AW-1:0] mmse_addr, avg_addr, eq_addr;
    logic [DW-1:0] mmse_wdata, avg_wdata;
    logic          mmse_gnt, avg_gnt, eq_gnt, avg_rvalid, eq_rvalid;
    logic [DW-1:0] avg_rdata, eq_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    est_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .mmse_req(mmse_req), .mmse_addr(mmse_addr), .mmse_wdata(mmse_wdata), .mmse_gnt(mmse_gnt),
        .avg_req(avg_req), .avg_we(avg_we), .avg_lock(avg_lock), .avg_addr(avg_addr),
        .avg_wdata(avg_wdata), .avg_gnt(avg_gnt), .avg_rvalid(avg_rvalid), .avg_rdata(avg_rdata),
        .eq_req(eq_req), .eq_addr(eq_addr), .eq_gnt(eq_gnt), .eq_rvalid(eq_rvalid), .eq_rdata(eq_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro stand-in, driven only by the DUT's RAM port.
    logic [DW-1:0] ram_mem [1024];
    // Reference memory, updated from the model's view of each transfer.
    logic [DW-1:0] ref_mem [1024];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = DW'(i * 3 + 16'h0400);
            ref_mem[i] = DW'(i * 3 + 16'h0400);
        end
        ram_mem[100] = 16'h2C16;
        ref_mem[100] = 16'h2C16;
        ram_rdata    = '0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata         <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: who wins a contested avg/eq tie next, whether avg
    // holds a reservation, and how long each of avg/eq has been waiting.
    bit            m_eq_turn;
    bit            m_locked;
    int            m_wait_avg, m_wait_eq;
    int            m_win = NONE;
    bit            m_avg_rv, m_eq_rv;
    logic [DW-1:0] m_rd;

    function automatic int pick();
        bit starve_a, starve_e;
        starve_a = avg_req && (m_wait_avg >= LIMIT);
        starve_e = eq_req  && (m_wait_eq  >= LIMIT);
        if (rst)                   return NONE;
        if (m_locked && avg_req)   return AVG;
        if (starve_a && starve_e)  return m_eq_turn ? EQ : AVG;
        if (starve_a)              return AVG;
        if (starve_e)              return EQ;
        if (mmse_req)              return MMSE;
        if (avg_req && eq_req)     return m_eq_turn ? EQ : AVG;
        if (avg_req)               return AVG;
        if (eq_req)                return EQ;
        return NONE;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        m_win = pick();
        ea = (m_win == MMSE) ? mmse_addr : (m_win == AVG) ? avg_addr : (m_win == EQ) ? eq_addr : '0;
        ed = (m_win == MMSE) ? mmse_wdata : (m_win == AVG) ? avg_wdata : '0;
        check("mdl_mmse_gnt", 32'(mmse_gnt), 32'(m_win == MMSE));
        check("mdl_avg_gnt",  32'(avg_gnt),  32'(m_win == AVG));
        check("mdl_eq_gnt",   32'(eq_gnt),   32'(m_win == EQ));
        check("mdl_ram_en",   32'(ram_en),   32'(m_win != NONE));
        check("mdl_ram_we",   32'(ram_we),   32'(m_win == MMSE || (m_win == AVG && avg_we)));
        check("mdl_ram_addr", 32'(ram_addr), 32'(ea));
        check("mdl_ram_wdata", 32'(ram_wdata), 32'(ed));
        check("mdl_avg_rvalid", 32'(avg_rvalid), 32'(m_avg_rv && !rst));
        check("mdl_eq_rvalid",  32'(eq_rvalid),  32'(m_eq_rv && !rst));
        if (m_avg_rv && !rst) check("mdl_avg_rdata", 32'(avg_rdata), 32'(m_rd));
        if (m_eq_rv && !rst)  check("mdl_eq_rdata",  32'(eq_rdata),  32'(m_rd));
    end

    // Model state advance on the active edge, using the winner seen this cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_eq_turn = 0; m_locked = 0; m_wait_avg = 0; m_wait_eq = 0;
            m_avg_rv = 0; m_eq_rv = 0;
        end else begin
            m_locked   = (m_win == AVG) && avg_lock;
            if (m_win == AVG) m_eq_turn = 1;
            if (m_win == EQ)  m_eq_turn = 0;
            m_wait_avg = (avg_req && m_win != AVG) ? ((m_wait_avg < LIMIT) ? m_wait_avg + 1 : LIMIT) : 0;
            m_wait_eq  = (eq_req  && m_win != EQ)  ? ((m_wait_eq  < LIMIT) ? m_wait_eq  + 1 : LIMIT) : 0;
            m_avg_rv   = (m_win == AVG) && !avg_we;
            m_eq_rv    = (m_win == EQ);
            if (m_win == MMSE)           ref_mem[mmse_addr] = mmse_wdata;
            if (m_win == AVG && avg_we)  ref_mem[avg_addr]  = avg_wdata;
            if (m_win == AVG && !avg_we) m_rd = ref_mem[avg_addr];
            if (m_win == EQ)             m_rd = ref_mem[eq_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        mmse_req = 0; avg_req = 0; eq_req = 0; avg_we = 0; avg_lock = 0;
    endtask

    initial begin
        bit pm, pa, pe;
        // Reset with every request raised.
        rst = 1; mmse_req = 1; avg_req = 1; eq_req = 1; avg_we = 0; avg_lock = 0;
        mmse_addr = 10'd0; mmse_wdata = 16'h0001; avg_addr = 10'd2; avg_wdata = '0; eq_addr = 10'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_gnt", 32'({mmse_gnt, avg_gnt, eq_gnt}), 32'd0);
            check("rst_ram_en", 32'(ram_en), 32'd0);
            check("rst_rvalid", 32'({avg_rvalid, eq_rvalid}), 32'd0);
            tick();
        end
        rst = 0;
        @(negedge clk);
        check("post_rst_mmse_gnt", 32'(mmse_gnt), 32'd1);
        tick(); idle(); tick();

        // Starvation: eq waits behind MMSE for LIMIT cycles, then wins.
        mmse_req = 1; mmse_addr = 10'd10; mmse_wdata = 16'h0101;
        eq_req = 1; eq_addr = 10'd100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("starve_mmse_gnt", 32'(mmse_gnt), 32'(c < 4));
            check("starve_eq_gnt",   32'(eq_gnt),   32'(c == 4));
            tick();
        end
        idle();
        @(negedge clk);
        check("starve_eq_rvalid", 32'(eq_rvalid), 32'd1);
        check("starve_eq_rdata",  32'(eq_rdata),  32'h2C16);
        tick();

        // Round-robin between avg and eq reads, starting with avg.
        avg_req = 1; avg_addr = 10'd10; eq_req = 1; eq_addr = 10'd100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rr_avg_gnt", 32'(avg_gnt), 32'(c % 2 == 0));
            check("rr_eq_gnt",  32'(eq_gnt),  32'(c % 2 == 1));
            if (c == 1) check("rr_avg_rdata", 32'(avg_rdata), 32'h0101);
            if (c == 2) check("rr_eq_rdata",  32'(eq_rdata),  32'h2C16);
            tick();
        end
        idle(); tick();

        // Locked read-then-write by avg while MMSE keeps asking.
        mmse_req = 1; mmse_addr = 10'd20; mmse_wdata = 16'h5555;
        avg_req = 1; avg_we = 0; avg_lock = 1; avg_addr = 10'd5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("lock_pre_mmse_gnt", 32'(mmse_gnt), 32'd1);
            tick();
        end
        @(negedge clk);
        check("lock_rd_avg_gnt", 32'(avg_gnt), 32'd1);
        tick();
        avg_we = 1; avg_lock = 0; avg_wdata = 16'h7F80;
        @(negedge clk);
        check("lock_wr_avg_gnt", 32'(avg_gnt), 32'd1);
        check("lock_wr_ram_we",  32'(ram_we),  32'd1);
        check("lock_rd_rvalid",  32'(avg_rvalid), 32'd1);
        tick();
        avg_req = 0; avg_we = 0;
        @(negedge clk);
        check("lock_mmse_third", 32'(mmse_gnt), 32'd1);
        tick();
        idle(); eq_req = 1; eq_addr = 10'd5;
        tick();
        idle();
        @(negedge clk);
        check("lock_eq_rdata", 32'(eq_rdata), 32'h7F80);
        tick();

        // MMSE write at the top address.
        mmse_req = 1; mmse_addr = 10'd1023; mmse_wdata = 16'h1234;
        @(negedge clk);
        check("wr_ram_en",   32'(ram_en),   32'd1);
        check("wr_ram_we",   32'(ram_we),   32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'd1023);
        check("wr_ram_wdata", 32'(ram_wdata), 32'h1234);
        tick(); idle();
        @(negedge clk);
        check("wr_no_rvalid", 32'({avg_rvalid, eq_rvalid}), 32'd0);
        tick();

        // Reset arriving right after an eq read grant.
        avg_req = 1; avg_addr = 10'd7;
        tick();
        eq_req = 1; eq_addr = 10'd100;
        @(negedge clk);
        check("midrst_eq_gnt", 32'(eq_gnt), 32'd1);
        tick();
        rst = 1; eq_req = 0; avg_lock = 1;
        @(negedge clk);
        check("midrst_eq_rvalid", 32'(eq_rvalid), 32'd0);
        check("midrst_gnt", 32'({mmse_gnt, avg_gnt, eq_gnt}), 32'd0);
        tick(); tick();
        rst = 0; avg_req = 0; avg_lock = 0; mmse_req = 1; mmse_addr = 10'd30; eq_req = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_cnt_eq_gnt", 32'(eq_gnt), 32'(c == 4));
            tick();
        end
        idle(); tick();

        // Soak: requests stay up until granted; the model checks every cycle.
        pm = 0; pa = 0; pe = 0;
        for (int c = 0; c < 400; c++) begin
            if (m_win == MMSE) pm = 0;
            if (m_win == AVG)  pa = 0;
            if (m_win == EQ)   pe = 0;
            if (!pm && ($urandom_range(3) == 0)) begin
                pm = 1; mmse_addr = AW'($urandom_range(15)); mmse_wdata = DW'($urandom);
            end
            if (!pa && ($urandom_range(1) == 0)) begin
                pa = 1; avg_addr = AW'($urandom_range(15)); avg_wdata = DW'($urandom);
                avg_we = 1'($urandom_range(1)); avg_lock = ($urandom_range(2) == 0);
            end
            if (!pe && ($urandom_range(1) == 0)) begin
                pe = 1; eq_addr = AW'($urandom_range(15));
            end
            mmse_req = pm; avg_req = pa; eq_req = pe;
            tick();
        end
        idle(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/est_ram_arbiter.md
Name: est_ram_arbiter

Overview:
- Single-port access arbiter for the estimation-chain RAM (16-bit {I,Q} words, 1024 deep).
- Shares the RAM between three requesters:
  - MMSE result writer.
  - Channel-averaging engine: reads, plus optional locked read-then-write pairs.
  - Equalizer read port.
- Fixed priority plus round-robin plus starvation guard, with a 1-cycle read-data return path.
- Sits between the mmse/ch_avg/equalizer logic and the RAM macro inside the estimation top.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- DATA_WIDTH, 16, RAM word width ({I[15:8],Q[7:0]}).
- STARVE_LIMIT, 4, denied cycles after which avg/eq become "starved" (range 1..15; counters 4 bits).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mmse_req  in  1  MMSE write request; held until granted.
- mmse_addr  in  ADDR_WIDTH  MMSE write address.
- mmse_wdata  in  DATA_WIDTH  MMSE write data.
- mmse_gnt  out  1  MMSE granted this cycle (combinational).
- avg_req  in  1  averaging request; held until granted.
- avg_we  in  1  1 = write, 0 = read.
- avg_lock  in  1  with a granted access: reserve the next cycle for avg.
- avg_addr  in  ADDR_WIDTH  averaging address.
- avg_wdata  in  DATA_WIDTH  averaging write data.
- avg_gnt  out  1  avg granted this cycle (combinational).
- avg_rvalid  out  1  avg read data valid.
- avg_rdata  out  DATA_WIDTH  avg read data.
- eq_req  in  1  equalizer read request; held until granted.
- eq_addr  in  ADDR_WIDTH  equalizer read address.
- eq_gnt  out  1  eq granted this cycle (combinational).
- eq_rvalid  out  1  eq read data valid.
- eq_rdata  out  DATA_WIDTH  eq read data.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after a read enable.

Behaviour:
- Handshake:
  - Requesters hold req, addr and data stable until gnt.
  - A transfer occurs in the cycle where req & gnt.
  - At most one gnt per cycle.
- Grant priority each cycle, first match wins:
  1. lock_r & avg_req → avg.
  2. Any starved requester (cnt == STARVE_LIMIT). If both are starved, rr_r decides.
  3. mmse_req → mmse.
  4. avg_req / eq_req by rr_r: 0 prefers avg, 1 prefers eq. A lone requester wins regardless of rr_r.
- State registers:
  - rr_r ← 1 after an avg grant; ← 0 after an eq grant; unchanged otherwise.
  - lock_r ← avg_gnt & avg_lock.
  - Lock lasts one cycle per assertion. Chains are allowed while avg_lock is held on each granted access.
  - If avg_req is low when lock_r is set, lock_r is simply dropped.
- Starvation counters, avg_cnt and eq_cnt:
  - Increment by 1, saturating at STARVE_LIMIT, on each cycle with req=1 and gnt=0.
  - Clear on grant or when req=0.
  - Lock overrides starvation; starved requesters keep waiting.
  - MMSE has no counter and may be delayed by starved or locked avg/eq.
- RAM drive (combinational from the winner):
  - ram_en = |gnt.
  - ram_we = mmse_gnt | (avg_gnt & avg_we).
  - ram_addr / ram_wdata are muxed from the winner.
  - ram_addr and ram_wdata = 0 when idle. wdata = 0 for eq.
- Read return:
  - avg_rvalid ← avg_gnt & ~avg_we.
  - eq_rvalid ← eq_gnt.
  - Latency = 1 cycle after grant.
  - avg_rdata = eq_rdata = ram_rdata; meaningful only when the matching rvalid is high.
- Reset:
  - All gnt and ram_en = 0 while rst=1.
  - rr_r = 0, lock_r = 0, counters = 0, rvalids = 0.
- Reset mid-operation: a read granted in the cycle before rst asserts returns no rvalid. Locks and counters are discarded.
- Simultaneous events:
  - Write and read to the same address in consecutive cycles: the read returns the new data (RAM write-first assumed at the macro; the arbiter adds no forwarding).
  - Lock plus a starved eq: avg wins; eq_cnt stays saturated and eq wins the next unlocked cycle.

Test Plan:
- Reset: rst=1 for 3 cycles with all reqs high → all gnt=0, ram_en=0, rvalids=0; first cycle after release with all three reqs high → mmse_gnt=1.
- Starvation: STARVE_LIMIT=4, mmse_req and eq_req held high from cycle 0 → mmse granted cycles 0-3, eq_gnt=1 in cycle 4, eq_rvalid=1 in cycle 5 with eq_rdata = RAM content at eq_addr (e.g. 16'h2C16).
- Round-robin: avg_req and eq_req (both reads) held high, mmse idle → grants alternate avg, eq, avg, eq starting with avg; each rvalid follows its grant by 1 cycle.
- Lock: avg read with avg_lock=1 at addr 5, then avg write to addr 5 with data 16'h7F80, while mmse_req is high → avg wins both cycles, mmse granted in the 3rd; subsequent eq read of addr 5 returns 16'h7F80.
- Write routing: mmse write of 16'h1234 at addr 1023 → ram_en=1, ram_we=1, ram_addr=1023 in the grant cycle; no rvalid pulse.
- Reset mid-read: eq granted at cycle N, rst=1 at cycle N+1 → eq_rvalid stays 0; counters, rr_r and lock_r return to 0.
